nv_ram_rws_64x18_fifo_ctrl: RTL and testbench
=============================================

NV_RAM_RWS_64X18_FIFO_CTRL -- requirements
Module: nv_ram_rws_64x18_fifo_ctrl

Interface
REQ-001 Parameters: none; depth fixed at 64 entries, width fixed at 18 bits.
REQ-002 nvdla_core_clk  input  1  single clock, all logic on rising edge.
REQ-003 nvdla_core_rstn  input  1  reset, synchronous, active-low.
REQ-004 wr_pvld  input  1  write request valid.
REQ-005 wr_prdy  output  1  write ready; push occurs when wr_pvld && wr_prdy.
REQ-006 wr_pd  input  18  write payload.
REQ-007 rd_pvld  output  1  read data valid.
REQ-008 rd_prdy  input  1  read ready; pop occurs when rd_pvld && rd_prdy.
REQ-009 rd_pd  output  18  read payload.
REQ-010 ram_we, ram_wa[5:0], ram_di[17:0]  output  RAM write port.
REQ-011 ram_re, ram_ra[5:0]  output  RAM read port; the RAM registers ra when re is high, and ram_dout = M[registered ra].
REQ-012 ram_dout  input  18  RAM read data.
REQ-013 count  output  7  occupancy, 0..64, including the entry presented on rd_pd.

Function
REQ-014 State SHALL be: wr_ptr[5:0], rd_ptr[5:0] (next RAM address to fetch), count[6:0], rd_pvld register.
REQ-015 wr_prdy SHALL be (count != 64) && nvdla_core_rstn; no push while full, even with a simultaneous pop.
REQ-016 On push: ram_we=1, ram_wa=wr_ptr, ram_di=wr_pd, and wr_ptr increments modulo 64 (63 -> 0); otherwise ram_we=0.
REQ-017 unfetched = count - rd_pvld; ram_re SHALL be (unfetched != 0) && (!rd_pvld || rd_prdy) && nvdla_core_rstn; ram_ra=rd_ptr.
REQ-018 On ram_re: rd_ptr increments modulo 64; rd_pvld is 1 the next cycle.
REQ-019 On pop without ram_re: rd_pvld is 0 the next cycle; with no pop and no ram_re, rd_pvld holds.
REQ-020 rd_pd SHALL be ram_dout directly, with no output register; it stays stable while rd_pvld && !rd_prdy because the RAM holds its read address while re is low.
REQ-021 count next = count + push - pop; simultaneous push and pop leave count unchanged.
REQ-022 A pushed entry SHALL be fetchable the cycle after the push: push in cycle N gives ram_re in N+1 and rd_pvld in N+2 (minimum latency 2).
REQ-023 Sustained push+pop at full throughput: one pop per cycle once primed; there are no bubbles while unfetched > 0.
REQ-024 Writes never target an address that has been fetched but not popped; the full check guarantees this.
REQ-025 Push while wr_pvld is high and the FIFO is full SHALL be ignored; the payload must be held by the sender.
REQ-026 Pop when rd_pvld=0 is not possible; rd_prdy is don't-care when empty.

Reset
REQ-027 While nvdla_core_rstn=0 at a clock edge, wr_ptr, rd_ptr, count and rd_pvld SHALL clear to 0.
REQ-028 During reset, wr_prdy=0, ram_we=0 and ram_re=0; RAM contents are not cleared.
REQ-029 Reset asserted mid-operation discards all entries; the first cycle after release has count=0, rd_pvld=0 and wr_prdy=1.

Verification
REQ-030 Reset, then push 0x3_FFFF in cycle 0 with rd_prdy=1 -> ram_re in cycle 1 (ra=0), rd_pvld=1 and rd_pd=0x3_FFFF in cycle 2, count 1 -> 0 after the pop.
REQ-031 Push 64 entries 0..63 with rd_prdy=0 -> count=64 and wr_prdy=0; a 65th push is refused; draining returns 0..63 in order, and wr_prdy=1 after the first pop.
REQ-032 Stall: rd_pvld=1 with rd_pd=0x00AB and rd_prdy=0 for 10 cycles while 5 pushes occur -> rd_pd stays 0x00AB, ram_re=0, count rises by 5.
REQ-033 Wrap: 200 pushes/pops with random wr_pvld/rd_prdy (50%) -> output sequence equals input sequence, pointers wrap 63 -> 0, count never exceeds 64 or underflows.
REQ-034 Full with simultaneous pop and wr_pvld=1 -> the pop completes, no push that cycle, count=63, and the push is accepted the next cycle.
REQ-035 Reset asserted with count=17 and rd_pvld=1 -> the next cycle has count=0, rd_pvld=0, wr_prdy=0 during reset and 1 after release; the next push reads back correctly from address 0.

Source files
------------

// File: rtl/nv_ram_rws_64x18_fifo_ctrl.sv
// Control logic for a 64x18 FIFO built around an external RAM with a registered read address.
// rd_pd comes straight from ram_dout; the RAM holding its read address keeps it stable during a stall.
module nv_ram_rws_64x18_fifo_ctrl (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        wr_pvld,
  output logic        wr_prdy,
  input  logic [17:0] wr_pd,
  output logic        rd_pvld,
  input  logic        rd_prdy,
  output logic [17:0] rd_pd,
  output logic        ram_we,
  output logic [5:0]  ram_wa,
  output logic [17:0] ram_di,
  output logic        ram_re,
  output logic [5:0]  ram_ra,
  input  logic [17:0] ram_dout,
  output logic [6:0]  count
);

  logic [5:0] wr_ptr;
  logic [5:0] rd_ptr;
  logic       push;
  logic       pop;
  logic [6:0] unfetched;

  // Full blocks writes even when a pop happens in the same cycle, so a write
  // can never land on the entry that is currently presented on rd_pd.
  assign wr_prdy   = (count != 7'd64) && nvdla_core_rstn;
  assign push      = wr_pvld && wr_prdy;
  assign pop       = rd_pvld && rd_prdy;
  assign unfetched = count - {6'd0, rd_pvld};

  assign ram_re = (unfetched != 7'd0) && (!rd_pvld || rd_prdy) && nvdla_core_rstn;
  assign ram_ra = rd_ptr;
  assign ram_we = push;
  assign ram_wa = wr_ptr;
  assign ram_di = wr_pd;
  assign rd_pd  = ram_dout;

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      wr_ptr  <= 6'd0;
      rd_ptr  <= 6'd0;
      count   <= 7'd0;
      rd_pvld <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 6'd1;
      end
      if (ram_re) begin
        rd_ptr <= rd_ptr + 6'd1;
      end
      if (ram_re) begin
        rd_pvld <= 1'b1;
      end else if (pop) begin
        rd_pvld <= 1'b0;
      end
      count <= count + {6'd0, push} - {6'd0, pop};
    end
  end

endmodule

// File: tb/tb_nv_ram_rws_64x18_fifo_ctrl.sv
// Directed and randomized checks of the 64x18 FIFO controller against a behavioural RAM and a queue model.
module tb_nv_ram_rws_64x18_fifo_ctrl;

  logic        nvdla_core_clk;
  logic        nvdla_core_rstn;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [17:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [17:0] rd_pd;
  logic        ram_we;
  logic [5:0]  ram_wa;
  logic [17:0] ram_di;
  logic        ram_re;
  logic [5:0]  ram_ra;
  logic [17:0] ram_dout;
  logic [6:0]  count;

  logic [17:0] mem [64];
  logic [5:0]  ra_q;

  int assertCount = 0;
  int failCount   = 0;

  nv_ram_rws_64x18_fifo_ctrl dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .wr_pvld         (wr_pvld),
    .wr_prdy         (wr_prdy),
    .wr_pd           (wr_pd),
    .rd_pvld         (rd_pvld),
    .rd_prdy         (rd_prdy),
    .rd_pd           (rd_pd),
    .ram_we          (ram_we),
    .ram_wa          (ram_wa),
    .ram_di          (ram_di),
    .ram_re          (ram_re),
    .ram_ra          (ram_ra),
    .ram_dout        (ram_dout),
    .count           (count)
  );

  initial begin
    nvdla_core_clk = 1'b0;
    forever #5 nvdla_core_clk = ~nvdla_core_clk;
  end

  // RAM model: registered read address, contents untouched by reset.
  initial ra_q = 6'd0;
  always @(posedge nvdla_core_clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_q <= ram_ra;
  end
  assign ram_dout = mem[ra_q];

  task automatic applyStimulus(input logic wv, input logic [17:0] wd, input logic rp);
    wr_pvld = wv;
    wr_pd   = wd;
    rd_prdy = rp;
  endtask

  task automatic tick();
    @(posedge nvdla_core_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [17:0] q [$];
    logic [17:0] data;
    logic        wv;
    logic        rp;
    logic        doPush;
    int          pushes;
    int          pops;
    int          cycles;

    nvdla_core_rstn = 1'b0;
    applyStimulus(1'b1, 18'h12345, 1'b1);
    #4;
    checkOutput("rst_wr_prdy", wr_prdy, 0);
    checkOutput("rst_ram_we", ram_we, 0);
    checkOutput("rst_ram_re", ram_re, 0);
    tick();
    tick();
    checkOutput("rst_count", count, 0);
    checkOutput("rst_rd_pvld", rd_pvld, 0);
    nvdla_core_rstn = 1'b1;

    // Single entry latency
    applyStimulus(1'b1, 18'h3FFFF, 1'b1);
    #4;
    checkOutput("lat_wr_prdy", wr_prdy, 1);
    checkOutput("lat_ram_we", ram_we, 1);
    checkOutput("lat_ram_wa", ram_wa, 0);
    checkOutput("lat_ram_di", ram_di, 18'h3FFFF);
    checkOutput("lat_ram_re0", ram_re, 0);
    tick();
    applyStimulus(1'b0, 18'h0, 1'b1);
    #4;
    checkOutput("lat_count1", count, 1);
    checkOutput("lat_ram_re1", ram_re, 1);
    checkOutput("lat_ram_ra", ram_ra, 0);
    checkOutput("lat_rd_pvld1", rd_pvld, 0);
    tick();
    #4;
    checkOutput("lat_rd_pvld2", rd_pvld, 1);
    checkOutput("lat_rd_pd", rd_pd, 18'h3FFFF);
    checkOutput("lat_count2", count, 1);
    checkOutput("lat_ram_re2", ram_re, 0);
    tick();
    #4;
    checkOutput("lat_count3", count, 0);
    checkOutput("lat_rd_pvld3", rd_pvld, 0);

    // Fill to 64, refuse a 65th, drain in order
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 18'(i), 1'b0);
      #4;
      checkOutput("fill_ram_we", ram_we, 1);
      checkOutput("fill_ram_wa", ram_wa, (i + 1) % 64);
      tick();
    end
    applyStimulus(1'b1, 18'h3AAAA, 1'b0);
    #4;
    checkOutput("full_count", count, 64);
    checkOutput("full_wr_prdy", wr_prdy, 0);
    checkOutput("full_ram_we", ram_we, 0);
    checkOutput("full_rd_pvld", rd_pvld, 1);
    tick();
    #4;
    checkOutput("full_count_hold", count, 64);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b0, 18'h0, 1'b1);
      #4;
      checkOutput("drain_rd_pvld", rd_pvld, 1);
      checkOutput("drain_rd_pd", rd_pd, i);
      if (i == 1) checkOutput("drain_wr_prdy", wr_prdy, 1);
      tick();
    end
    #4;
    checkOutput("drain_count", count, 0);
    checkOutput("drain_rd_pvld_end", rd_pvld, 0);

    // Full with simultaneous pop and push request
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 18'(32'h100 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b1, 18'h01234, 1'b1);
    #4;
    checkOutput("fpop_wr_prdy", wr_prdy, 0);
    checkOutput("fpop_ram_we", ram_we, 0);
    checkOutput("fpop_rd_pd", rd_pd, 18'h100);
    tick();
    applyStimulus(1'b1, 18'h01234, 1'b0);
    #4;
    checkOutput("fpop_count63", count, 63);
    checkOutput("fpop_wr_prdy2", wr_prdy, 1);
    checkOutput("fpop_ram_we2", ram_we, 1);
    checkOutput("fpop_ram_wa", ram_wa, 1);
    tick();
    #4;
    checkOutput("fpop_count64", count, 64);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b0, 18'h0, 1'b1);
      #4;
      checkOutput("fpop_drain_pd", rd_pd, (i < 63) ? (32'h101 + i) : 32'h1234);
      tick();
    end

    // Stall with pushes arriving behind the presented entry
    applyStimulus(1'b1, 18'h000AB, 1'b0);
    tick();
    applyStimulus(1'b0, 18'h0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i < 5, 18'(32'h200 + i), 1'b0);
      #4;
      checkOutput("stall_rd_pvld", rd_pvld, 1);
      checkOutput("stall_rd_pd", rd_pd, 18'h000AB);
      checkOutput("stall_ram_re", ram_re, 0);
      checkOutput("stall_count", count, (i < 5) ? (1 + i) : 6);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 18'h0, 1'b1);
      #4;
      checkOutput("stall_drain_pd", rd_pd, (i == 0) ? 32'hAB : (32'h200 + i - 1));
      tick();
    end
    #4;
    checkOutput("stall_count_end", count, 0);

    // Reset mid-operation
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 18'(32'h300 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 18'h0, 1'b0);
    #4;
    checkOutput("mrst_pre_count", count, 17);
    checkOutput("mrst_pre_rd_pvld", rd_pvld, 1);
    nvdla_core_rstn = 1'b0;
    applyStimulus(1'b1, 18'h00777, 1'b1);
    #1;
    checkOutput("mrst_wr_prdy", wr_prdy, 0);
    checkOutput("mrst_ram_we", ram_we, 0);
    checkOutput("mrst_ram_re", ram_re, 0);
    tick();
    #4;
    checkOutput("mrst_count", count, 0);
    checkOutput("mrst_rd_pvld", rd_pvld, 0);
    checkOutput("mrst_wr_prdy_held", wr_prdy, 0);
    tick();
    nvdla_core_rstn = 1'b1;
    applyStimulus(1'b1, 18'h25A5A, 1'b0);
    #4;
    checkOutput("mrst_rel_wr_prdy", wr_prdy, 1);
    checkOutput("mrst_rel_count", count, 0);
    checkOutput("mrst_rel_ram_wa", ram_wa, 0);
    checkOutput("mrst_rel_ram_we", ram_we, 1);
    tick();
    applyStimulus(1'b0, 18'h0, 1'b1);
    #4;
    checkOutput("mrst_ram_re1", ram_re, 1);
    checkOutput("mrst_ram_ra", ram_ra, 0);
    tick();
    #4;
    checkOutput("mrst_rd_pvld1", rd_pvld, 1);
    checkOutput("mrst_rd_pd", rd_pd, 18'h25A5A);
    tick();
    #4;
    checkOutput("mrst_count_end", count, 0);

    // Random traffic against a queue model, crossing the pointer wrap several times
    pushes = 0;
    pops   = 0;
    cycles = 0;
    while ((pushes < 200 || pops < 200) && cycles < 4000) begin
      wv   = (pushes < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
      data = 18'($urandom);
      rp   = 1'($urandom_range(0, 1));
      applyStimulus(wv, data, rp);
      #4;
      doPush = wv && (q.size() != 64);
      checkOutput("rand_wr_prdy", wr_prdy, q.size() != 64);
      checkOutput("rand_ram_we", ram_we, doPush);
      checkOutput("rand_count", count, q.size());
      if (rd_pvld && rd_prdy) begin
        checkOutput("rand_pop_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          checkOutput("rand_rd_pd", rd_pd, q.pop_front());
          pops++;
        end
      end
      if (doPush) begin
        q.push_back(data);
        pushes++;
      end
      tick();
      cycles++;
    end
    checkOutput("rand_completed", (pushes >= 200) && (pops >= 200), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
